hapb_wr_arbiter: RTL and testbench

HAPB_WR_ARBITER -- requirements
Module: hapb_wr_arbiter

---
 rtl/hapb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/hapb_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_hapb_wr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hapb_pkg.sv
// Shared types and AXI tie-off constants for the hot-page/hot-cache write arbiter.
package hapb_pkg;

   typedef enum logic {
      StIdle,
      StXfer
   } state_e;

   typedef logic req_idx_t;

   localparam logic [7:0] AXLEN_SINGLE   = 8'd0;
   localparam logic [2:0] AXSIZE_64B     = 3'b110;
   localparam logic [1:0] AXBURST_FIXED  = 2'b00;
   localparam logic [2:0] AXPROT_ZERO    = 3'b000;
   localparam logic [3:0] AXQOS_ZERO     = 4'h0;
   localparam logic [3:0] AXCACHE_ZERO   = 4'h0;
   localparam logic [3:0] AXREGION_ZERO  = 4'h0;
   localparam logic [5:0] AWATOP_NONE    = 6'h00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted requester has lowest priority.
module rr_arb2
   import hapb_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic [1:0] o_gnt,
   output req_idx_t   o_idx
);

   req_idx_t r_last;

   always_comb begin
      o_idx = 1'b0;
      o_gnt = 2'b00;
      if (i_req == 2'b11) begin
         o_idx = ~r_last;
      end else if (i_req[1]) begin
         o_idx = 1'b1;
      end
      if (i_req != 2'b00) begin
         o_gnt = o_idx ? 2'b10 : 2'b01;
      end
   end

   // Reset value 1 makes s0 the preferred requester out of reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= 1'b1;
      end else if (i_en && (i_req != 2'b00)) begin
         r_last <= o_idx;
      end
   end

endmodule

// File: rtl/hapb_wr_arbiter.sv
// Arbitrates two single-beat AXI write requesters onto one downstream AXI4 write port,
// tracking per-requester outstanding writes and routing B responses by bid[0].
module hapb_wr_arbiter
   import hapb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ID_W            = 12
) (
   input  logic              axi4_mm_clk,
   input  logic              axi4_mm_rst,
   // requester 0: hot page pusher
   input  logic              s0_awvalid,
   output logic              s0_awready,
   input  logic [63:0]       s0_awaddr,
   input  logic [ID_W-2:0]   s0_awid,
   input  logic [5:0]        s0_awuser,
   input  logic              s0_wvalid,
   output logic              s0_wready,
   input  logic [511:0]      s0_wdata,
   input  logic [63:0]       s0_wstrb,
   output logic              s0_bvalid,
   input  logic              s0_bready,
   output logic [1:0]        s0_bresp,
   // requester 1: hot cache pusher
   input  logic              s1_awvalid,
   output logic              s1_awready,
   input  logic [63:0]       s1_awaddr,
   input  logic [ID_W-2:0]   s1_awid,
   input  logic [5:0]        s1_awuser,
   input  logic              s1_wvalid,
   output logic              s1_wready,
   input  logic [511:0]      s1_wdata,
   input  logic [63:0]       s1_wstrb,
   output logic              s1_bvalid,
   input  logic              s1_bready,
   output logic [1:0]        s1_bresp,
   // downstream AXI4 write port
   output logic              awvalid,
   input  logic              awready,
   output logic [63:0]       awaddr,
   output logic [ID_W-1:0]   awid,
   output logic [5:0]        awuser,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [2:0]        awprot,
   output logic [3:0]        awqos,
   output logic [3:0]        awcache,
   output logic              awlock,
   output logic [3:0]        awregion,
   output logic [5:0]        awatop,
   output logic              wvalid,
   input  logic              wready,
   output logic [511:0]      wdata,
   output logic [63:0]       wstrb,
   output logic              wlast,
   output logic [0:0]        wuser,
   input  logic              bvalid,
   output logic              bready,
   input  logic [ID_W-1:0]   bid,
   input  logic [1:0]        bresp
);

   localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   state_e           r_state, w_state_nxt;
   req_idx_t         r_gnt, w_gnt_nxt, w_arb_idx;
   logic             r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
   logic [CNT_W-1:0] r_cnt0, r_cnt1;
   logic [1:0]       w_elig, w_arb_gnt;
   logic             w_in_xfer, w_sel_awvalid, w_sel_wvalid, w_aw_hs, w_w_hs;
   logic             w_inc0, w_inc1, w_dec0, w_dec1;
   logic             w_unused_bid;

   assign w_elig[0] = s0_awvalid & s0_wvalid & (r_cnt0 < CNT_MAX);
   assign w_elig[1] = s1_awvalid & s1_wvalid & (r_cnt1 < CNT_MAX);

   rr_arb2 u_rr_arb2 (
      .i_clk (axi4_mm_clk),
      .i_rst (axi4_mm_rst),
      .i_req (w_elig),
      .i_en  (r_state == StIdle),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx)
   );

   assign w_in_xfer     = (r_state == StXfer);
   assign w_sel_awvalid = r_gnt ? s1_awvalid : s0_awvalid;
   assign w_sel_wvalid  = r_gnt ? s1_wvalid  : s0_wvalid;

   // Each channel's valid is masked once its own handshake has completed.
   assign awvalid = w_in_xfer & w_sel_awvalid & ~r_aw_done;
   assign wvalid  = w_in_xfer & w_sel_wvalid  & ~r_w_done;
   assign w_aw_hs = awvalid & awready;
   assign w_w_hs  = wvalid & wready;

   assign s0_awready = w_in_xfer & ~r_gnt & ~r_aw_done & awready;
   assign s1_awready = w_in_xfer &  r_gnt & ~r_aw_done & awready;
   assign s0_wready  = w_in_xfer & ~r_gnt & ~r_w_done  & wready;
   assign s1_wready  = w_in_xfer &  r_gnt & ~r_w_done  & wready;

   assign awaddr = w_in_xfer ? (r_gnt ? s1_awaddr : s0_awaddr) : '0;
   assign awid   = w_in_xfer ? {(r_gnt ? s1_awid : s0_awid), r_gnt} : '0;
   assign awuser = w_in_xfer ? (r_gnt ? s1_awuser : s0_awuser) : '0;
   assign wdata  = w_in_xfer ? (r_gnt ? s1_wdata : s0_wdata) : '0;
   assign wstrb  = w_in_xfer ? (r_gnt ? s1_wstrb : s0_wstrb) : '0;

   assign awlen    = AXLEN_SINGLE;
   assign awsize   = AXSIZE_64B;
   assign awburst  = AXBURST_FIXED;
   assign awprot   = AXPROT_ZERO;
   assign awqos    = AXQOS_ZERO;
   assign awcache  = AXCACHE_ZERO;
   assign awlock   = 1'b0;
   assign awregion = AXREGION_ZERO;
   assign awatop   = AWATOP_NONE;
   assign wuser    = 1'b0;
   assign wlast    = 1'b1;

   // B responses are forwarded even with a zero count, and held off during reset.
   assign s0_bvalid = bvalid & ~bid[0] & ~axi4_mm_rst;
   assign s1_bvalid = bvalid &  bid[0] & ~axi4_mm_rst;
   assign bready    = ~axi4_mm_rst & (bid[0] ? s1_bready : s0_bready);
   assign s0_bresp  = bresp;
   assign s1_bresp  = bresp;
   assign w_unused_bid = ^bid[ID_W-1:1];

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      unique case (r_state)
         StIdle: begin
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            if (w_arb_gnt != 2'b00) begin
               w_state_nxt = StXfer;
               w_gnt_nxt   = w_arb_idx;
            end
         end
         StXfer: begin
            if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
               w_state_nxt   = StIdle;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end else begin
               w_aw_done_nxt = r_aw_done | w_aw_hs;
               w_w_done_nxt  = r_w_done | w_w_hs;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
      if (axi4_mm_rst) begin
         r_state   <= StIdle;
         r_gnt     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
      end
   end

   assign w_inc0 = w_aw_hs & ~r_gnt;
   assign w_inc1 = w_aw_hs &  r_gnt;
   assign w_dec0 = s0_bvalid & s0_bready;
   assign w_dec1 = s1_bvalid & s1_bready;

   always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
      if (axi4_mm_rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_inc0 && !w_dec0) begin
            r_cnt0 <= r_cnt0 + 1'b1;
         end else if (!w_inc0 && w_dec0 && (r_cnt0 != '0)) begin
            r_cnt0 <= r_cnt0 - 1'b1;
         end
         if (w_inc1 && !w_dec1) begin
            r_cnt1 <= r_cnt1 + 1'b1;
         end else if (!w_inc1 && w_dec1 && (r_cnt1 != '0)) begin
            r_cnt1 <= r_cnt1 - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hapb_wr_arbiter.sv
// Directed self-checking bench for hapb_wr_arbiter.
module tb_hapb_wr_arbiter;
   import hapb_pkg::*;

   localparam int ID_W = 12;
   localparam logic [63:0]  A0 = 64'h0000_0000_0000_1000;
   localparam logic [63:0]  A1 = 64'h0000_0000_0000_2000;
   localparam logic [10:0]  I0 = 11'h155;
   localparam logic [10:0]  I1 = 11'h2AA;
   localparam logic [511:0] D0 = {16{32'hA0A0_0000}};
   localparam logic [511:0] D1 = {16{32'hB1B1_1111}};

   logic clk = 1'b0;
   logic rst;
   logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
   logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
   logic [63:0] s0_awaddr, s1_awaddr;
   logic [10:0] s0_awid, s1_awid;
   logic [5:0] s0_awuser, s1_awuser;
   logic [511:0] s0_wdata, s1_wdata;
   logic [63:0] s0_wstrb, s1_wstrb;
   logic [1:0] s0_bresp, s1_bresp;
   logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
   logic [63:0] awaddr;
   logic [ID_W-1:0] awid, bid;
   logic [5:0] awuser, awatop;
   logic [7:0] awlen;
   logic [2:0] awsize, awprot;
   logic [1:0] awburst, bresp;
   logic [3:0] awqos, awcache, awregion;
   logic [511:0] wdata;
   logic [63:0] wstrb;
   logic [0:0] wuser;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   hapb_wr_arbiter dut (
      .axi4_mm_clk(clk), .axi4_mm_rst(rst),
      .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
      .s0_awid(s0_awid), .s0_awuser(s0_awuser), .s0_wvalid(s0_wvalid),
      .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
      .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
      .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
      .s1_awid(s1_awid), .s1_awuser(s1_awuser), .s1_wvalid(s1_wvalid),
      .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
      .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awuser(awuser), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awprot(awprot), .awqos(awqos), .awcache(awcache), .awlock(awlock),
      .awregion(awregion), .awatop(awatop), .wvalid(wvalid), .wready(wready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s0_awvalid = 0; s0_wvalid = 0; s0_bready = 0;
      s1_awvalid = 0; s1_wvalid = 0; s1_bready = 0;
      s0_awaddr = A0; s0_awid = I0; s0_awuser = 6'h05; s0_wdata = D0; s0_wstrb = '1;
      s1_awaddr = A1; s1_awid = I1; s1_awuser = 6'h2A; s1_wdata = D1; s1_wstrb = '1;
      awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bvalid = 1'b1;
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1;
      awready = 1; wready = 1;
      @(negedge clk);
      n_checks++; if ({awvalid, wvalid, s0_awready, s0_wready, s0_bvalid, bready} !== 6'b0)
         $display("FAIL rst_valids: got %b want 000000",
                  {awvalid, wvalid, s0_awready, s0_wready, s0_bvalid, bready});
      else n_pass++;
      n_checks++; if (dut.r_state !== StIdle || dut.r_cnt0 !== 3'd0 || dut.r_cnt1 !== 3'd0)
         $display("FAIL rst_state: got st=%0d c0=%0d c1=%0d want 0 0 0",
                  dut.r_state, dut.r_cnt0, dut.r_cnt1);
      else n_pass++;
      n_checks++; if ({awlen, awsize, awburst, wlast, awatop} !== {8'd0, 3'b110, 2'b00, 1'b1, 6'd0})
         $display("FAIL tieoffs: got len=%h size=%b burst=%b last=%b atop=%h",
                  awlen, awsize, awburst, wlast, awatop);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_single_s0();
      do_reset();
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1; awready = 1; wready = 1;
      @(negedge clk);
      n_checks++; if (awvalid !== 1'b0) $display("FAIL single_idle_awvalid: got %b want 0", awvalid);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++; if ({awvalid, wvalid, s0_awready, s0_wready, s1_awready, s1_wready} !== 6'b111100)
         $display("FAIL single_xfer_hs: got %b want 111100",
                  {awvalid, wvalid, s0_awready, s0_wready, s1_awready, s1_wready});
      else n_pass++;
      n_checks++; if (awid !== {I0, 1'b0} || awaddr !== A0 || wdata !== D0)
         $display("FAIL single_payload: got awid=%h addr=%h want awid=%h addr=%h",
                  awid, awaddr, {I0, 1'b0}, A0);
      else n_pass++;
      step();
      s0_awvalid = 0; s0_wvalid = 0;
      n_checks++; if (dut.r_cnt0 !== 3'd1 || dut.r_state !== StIdle)
         $display("FAIL single_cnt_up: got cnt=%0d st=%0d want 1 0", dut.r_cnt0, dut.r_state);
      else n_pass++;
      bvalid = 1; bid = 12'h7FE; bresp = 2'b10;
      @(negedge clk);
      n_checks++; if ({s0_bvalid, s1_bvalid, bready, s0_bresp} !== 5'b10110)
         $display("FAIL single_b_route: got %b want 10110", {s0_bvalid, s1_bvalid, bready, s0_bresp});
      else n_pass++;
      step();
      bvalid = 0;
      n_checks++; if (dut.r_cnt0 !== 3'd0) $display("FAIL single_cnt_down: got %0d want 0", dut.r_cnt0);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int  nhs = 0;
      logic exp_idx = 1'b0;
      logic pend = 1'b0;
      logic pend_id = 1'b0;
      do_reset();
      s0_awvalid = 1; s0_wvalid = 1; s1_awvalid = 1; s1_wvalid = 1;
      s0_bready = 1; s1_bready = 1; awready = 1; wready = 1;
      for (int c = 0; c < 80 && nhs < 16; c++) begin
         @(negedge clk);
         if (awvalid && awready) begin
            n_checks++;
            if (awid[0] !== exp_idx || !wvalid || awaddr !== (exp_idx ? A1 : A0) ||
                wdata !== (exp_idx ? D1 : D0) || awid[11:1] !== (exp_idx ? I1 : I0))
               $display("FAIL rr_grant%0d: got idx=%b addr=%h wv=%b want idx=%b addr=%h",
                        nhs, awid[0], awaddr, wvalid, exp_idx, exp_idx ? A1 : A0);
            else n_pass++;
            pend = 1'b1;
            pend_id = awid[0];
            exp_idx = ~exp_idx;
            nhs++;
         end
         step();
         bvalid = pend;
         bid = {11'd0, pend_id};
         pend = 1'b0;
      end
      bvalid = 0;
      n_checks++; if (nhs != 16) $display("FAIL rr_count: got %0d want 16", nhs);
      else n_pass++;
   endtask

   task automatic test_w_stall();
      do_reset();
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1; awready = 1; wready = 0;
      step();
      @(negedge clk);
      n_checks++; if ({awvalid, s0_awready, s0_wready} !== 3'b110)
         $display("FAIL stall_aw_hs: got %b want 110", {awvalid, s0_awready, s0_wready});
      else n_pass++;
      step();
      s0_awvalid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1 || dut.r_state !== StXfer)
            $display("FAIL stall_wait%0d: got awv=%b wv=%b st=%0d want 0 1 1",
                     i, awvalid, wvalid, dut.r_state);
         else n_pass++;
         step();
      end
      wready = 1;
      @(negedge clk);
      n_checks++; if ({wvalid, s0_wready} !== 2'b11)
         $display("FAIL stall_w_hs: got %b want 11", {wvalid, s0_wready});
      else n_pass++;
      step();
      s0_wvalid = 0;
      n_checks++; if (dut.r_state !== StIdle || dut.r_cnt0 !== 3'd1)
         $display("FAIL stall_exit: got st=%0d cnt=%0d want 0 1", dut.r_state, dut.r_cnt0);
      else n_pass++;
   endtask

   task automatic test_max_outstanding();
      int nhs = 0;
      logic seen = 1'b0;
      do_reset();
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1; s1_bready = 1;
      awready = 1; wready = 1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (awvalid && awready) nhs++;
         step();
      end
      n_checks++; if (nhs != 4 || dut.r_cnt0 !== 3'd4)
         $display("FAIL max_fill: got hs=%0d cnt=%0d want 4 4", nhs, dut.r_cnt0);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (awvalid !== 1'b0 || dut.r_state !== StIdle)
            $display("FAIL max_block%0d: got awv=%b st=%0d want 0 0", c, awvalid, dut.r_state);
         else n_pass++;
         step();
      end
      s1_awvalid = 1; s1_wvalid = 1;
      step();
      @(negedge clk);
      n_checks++; if (awvalid !== 1'b1 || awid !== {I1, 1'b1} || awaddr !== A1)
         $display("FAIL max_s1_grant: got awv=%b awid=%h want 1 %h", awvalid, awid, {I1, 1'b1});
      else n_pass++;
      step();
      s1_awvalid = 0; s1_wvalid = 0;
      bvalid = 1; bid = '0;
      @(negedge clk);
      n_checks++; if ({s0_bvalid, bready} !== 2'b11)
         $display("FAIL max_b0: got %b want 11", {s0_bvalid, bready});
      else n_pass++;
      step();
      bvalid = 0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(negedge clk);
         if (awvalid) begin
            seen = 1'b1;
            n_checks++; if (awid !== {I0, 1'b0})
               $display("FAIL max_s0_reenable: got awid=%h want %h", awid, {I0, 1'b0});
            else n_pass++;
         end
         step();
      end
      n_checks++; if (!seen) $display("FAIL max_s0_timeout: got no grant want s0 grant");
      else n_pass++;
      s0_awvalid = 0; s0_wvalid = 0;
   endtask

   task automatic test_simul_inc_dec();
      do_reset();
      s1_awvalid = 1; s1_wvalid = 1; s1_bready = 1; awready = 1; wready = 1;
      step();
      step();
      n_checks++; if (dut.r_cnt1 !== 3'd1) $display("FAIL simul_pre: got %0d want 1", dut.r_cnt1);
      else n_pass++;
      step();
      bvalid = 1; bid = 12'h001;
      @(negedge clk);
      n_checks++; if ({awvalid, awid[0], s1_bvalid, bready} !== 4'b1111)
         $display("FAIL simul_same_cycle: got %b want 1111", {awvalid, awid[0], s1_bvalid, bready});
      else n_pass++;
      step();
      bvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
      n_checks++; if (dut.r_cnt1 !== 3'd1) $display("FAIL simul_cnt: got %0d want 1", dut.r_cnt1);
      else n_pass++;
   endtask

   task automatic test_b_saturate();
      do_reset();
      s0_bready = 1; s1_bready = 0;
      bvalid = 1; bid = 12'h000; bresp = 2'b11;
      @(negedge clk);
      n_checks++; if ({s0_bvalid, s1_bvalid, bready, s0_bresp} !== 5'b10111)
         $display("FAIL sat_forward: got %b want 10111", {s0_bvalid, s1_bvalid, bready, s0_bresp});
      else n_pass++;
      step();
      n_checks++; if (dut.r_cnt0 !== 3'd0) $display("FAIL sat_cnt: got %0d want 0", dut.r_cnt0);
      else n_pass++;
      bid = 12'h001;
      @(negedge clk);
      n_checks++; if ({s0_bvalid, s1_bvalid, bready} !== 3'b010)
         $display("FAIL sat_ready_sel: got %b want 010", {s0_bvalid, s1_bvalid, bready});
      else n_pass++;
      step();
      bvalid = 0;
   endtask

   task automatic test_reset_mid_xfer();
      do_reset();
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1; awready = 1; wready = 0;
      step();
      step();
      s0_awvalid = 0;
      n_checks++; if (dut.r_cnt0 !== 3'd1 || dut.r_state !== StXfer)
         $display("FAIL midrst_pre: got cnt=%0d st=%0d want 1 1", dut.r_cnt0, dut.r_state);
      else n_pass++;
      rst = 1; bvalid = 1; bid = '0;
      @(negedge clk);
      n_checks++; if ({awvalid, wvalid, s0_awready, s0_wready, s0_bvalid, bready} !== 6'b0)
         $display("FAIL midrst_valids: got %b want 000000",
                  {awvalid, wvalid, s0_awready, s0_wready, s0_bvalid, bready});
      else n_pass++;
      n_checks++; if (dut.r_state !== StIdle || dut.r_cnt0 !== 3'd0)
         $display("FAIL midrst_state: got st=%0d cnt=%0d want 0 0", dut.r_state, dut.r_cnt0);
      else n_pass++;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_s0();
      test_round_robin();
      test_w_stall();
      test_max_outstanding();
      test_simul_inc_dec();
      test_b_saturate();
      test_reset_mid_xfer();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
